nn_mem_arbiter: RTL and testbench
=================================

Name: nn_mem_arbiter

Overview:
- Shares the single-port network weight/activation BRAM between NUM_REQ requesters: layer engine, weight loader and host readback.
- Grants one memory access per cycle using round-robin priority.
- A requester may lock the memory for burst weight/activation streaming; a timeout bounds the lock.
- Returns read data to the requester that issued the read, after a fixed read latency.

Parameters:
NUM_REQ, 3, number of requesters (>=2)
ADDR_W, 16, memory address width
DATA_W, 32, memory word width (IEEE-754 single in current use)
RD_LAT, 1, BRAM read latency in cycles (>=1)
LOCK_MAX, 16, max consecutive locked cycles while another requester waits

Ports:
clk_i  in  1  clock
reset_ni  in  1  asynchronous active-low reset
req_i  in  NUM_REQ  per-requester access request
we_i  in  NUM_REQ  per-requester write enable (qualifies req_i)
lock_i  in  NUM_REQ  per-requester lock hold
addr_i  in  NUM_REQ*ADDR_W  packed addresses, requester k at [k*ADDR_W +: ADDR_W]
wdata_i  in  NUM_REQ*DATA_W  packed write data
gnt_o  out  NUM_REQ  one-hot grant, same cycle as req_i
rvalid_o  out  NUM_REQ  one-hot read-data valid
rdata_o  out  DATA_W  read data, shared; qualified by rvalid_o
mem_ena_o  out  1  BRAM enable
mem_wr_ena_o  out  1  BRAM write enable
mem_addr_o  out  ADDR_W  BRAM address
mem_wdata_o  out  DATA_W  BRAM write data
mem_rdata_i  in  DATA_W  BRAM read data

Behaviour:
- Reset (async, reset_ni=0) values:
  - state=ARB; rr_ptr=NUM_REQ-1, so requester 0 wins first.
  - lock_cnt=0; read-tag pipeline cleared.
  - Outputs gnt_o=0, rvalid_o=0, rdata_o=0, all mem_* outputs 0.
- Transfer: occurs in a cycle where gnt_o[k]=1.
  - gnt_o, mem_ena_o, mem_wr_ena_o, mem_addr_o and mem_wdata_o are combinational from the winner.
  - No request granted: mem_ena_o=0, mem_wr_ena_o=0.
- Write (we_i[k]=1): mem_wr_ena_o=1; no rvalid is generated.
- Read: a tag holding the winner's index shifts through an RD_LAT-deep pipeline.
  - rvalid_o[k]=1 exactly RD_LAT cycles after the grant.
  - rdata_o=mem_rdata_i in that cycle, 0 otherwise.
  - Back-to-back reads from different requesters return in grant order, one per cycle.
- State ARB:
  - Winner = first requester with req_i set, searching from rr_ptr+1 modulo NUM_REQ.
  - On a grant: rr_ptr<=winner.
  - If lock_i[winner]=1: owner<=winner, lock_cnt<=1, go to LOCKED.
- State LOCKED:
  - Only the owner can be granted. Owner req_i=0: no grant, state is held.
  - lock_i[owner]=0: the owner is still granted this cycle if it requests; then return to ARB.
  - lock_cnt increments each cycle while any other req_i is set, and saturates at LOCK_MAX.
  - lock_cnt==LOCK_MAX with another request pending: forced release to ARB, owner not granted that cycle.
  - The owner's lock_i must fall before it can lock again.
  - lock_cnt clears on entry to ARB.
- Simultaneous events:
  - lock_i without req_i in ARB has no effect.
  - Same-cycle req_i from all requesters: exactly one grant.
- Reset mid-operation: in-flight read tags are discarded. No rvalid_o follows reset deassertion until a new grant.
- Arithmetic:
  - rr_ptr and owner are $clog2(NUM_REQ) bits; the modulo wrap uses compare-and-reset, not power-of-two truncation.
  - lock_cnt is $clog2(LOCK_MAX+1) bits.

Optional Feature:
NN_ARB_STATS_EN:
- When defined, adds output stall_cnt_o (NUM_REQ*16 bits).
- Per-requester 16-bit saturating counter, incremented each cycle req_i[k]=1 and gnt_o[k]=0.
- Cleared by reset only.
- Undefined: port and counters are absent; no other behaviour changes.

Test Plan:
- Requester 0 reads addr 0x0005, memory returns 0x3F800000 -> gnt_o=3'b001 same cycle, mem_addr_o=0x0005; 1 cycle later rvalid_o=3'b001, rdata_o=0x3F800000.
- req_i=3'b111 held, no locks, reads -> grants 0,1,2,0,1,2; rvalid_o follows the same order delayed by RD_LAT.
- Requester 1 locks for 4 granted cycles, req 0 and 2 pending -> gnt_o=3'b010 for 4 cycles, then 3'b100, then 3'b001.
- LOCK_MAX=8, requester 1 holds lock 20 cycles, requester 0 pending -> 8 grants to 1, one cycle with no grant to 1, then gnt_o=3'b001.
- Requester 2 writes 0x40490FDB to 0x0100, then requester 0 reads 0x0100 -> mem_wr_ena_o=1 on the write only; rvalid_o[0] with rdata_o=0x40490FDB.
- Read granted, reset_ni pulled low the next cycle -> all outputs 0, no rvalid_o after release; with NN_ARB_STATS_EN, stall_cnt_o reads 0.

Source files
------------

// File: rtl/nn_mem_arbiter.sv
// nn_mem_arbiter: round-robin single-port BRAM arbiter with burst lock, lock timeout and read-data return; `define NN_ARB_STATS_EN adds stall_cnt_o
module nn_mem_arbiter #(
  parameter int NUM_REQ  = 3,
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 32,
  parameter int RD_LAT   = 1,
  parameter int LOCK_MAX = 16
) (
  input  logic                      clk_i,
  input  logic                      reset_ni,
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [NUM_REQ-1:0]        we_i,
  input  logic [NUM_REQ-1:0]        lock_i,
  input  logic [NUM_REQ*ADDR_W-1:0] addr_i,
  input  logic [NUM_REQ*DATA_W-1:0] wdata_i,
  output logic [NUM_REQ-1:0]        gnt_o,
  output logic [NUM_REQ-1:0]        rvalid_o,
  output logic [DATA_W-1:0]         rdata_o,
  output logic                      mem_ena_o,
  output logic                      mem_wr_ena_o,
  output logic [ADDR_W-1:0]         mem_addr_o,
  output logic [DATA_W-1:0]         mem_wdata_o,
  input  logic [DATA_W-1:0]         mem_rdata_i
`ifdef NN_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]     stall_cnt_o
`endif
);
  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = $clog2(LOCK_MAX + 1);
  localparam logic [PW-1:0] LAST = PW'(NUM_REQ - 1);
  localparam logic [CW-1:0] CMAX = CW'(LOCK_MAX);
  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

  typedef enum logic {ARB, LOCKED} state_t;

  state_t                 state_q, state_d;
  logic [PW-1:0]          rr_q, rr_d, own_q, own_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [NUM_REQ-1:0]     blk_q, blk_d;
  logic [RD_LAT-1:0]      tv_q, tv_d;
  logic [RD_LAT*PW-1:0]   ti_q, ti_d;
`ifdef NN_ARB_STATS_EN
  logic [NUM_REQ*16-1:0]  st_q, st_d;
`endif

  logic [PW-1:0] win, idx, gi, last_i;
  logic          found, other, force_rel, gv;

  // round-robin search starting one past the last winner, wrapping by compare
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = rr_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (idx == LAST) ? '0 : idx + PW'(1);
      if (!found && req_i[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign other     = |(req_i & ~(ONE << own_q));
  assign force_rel = (state_q == LOCKED) && (cnt_q == CMAX) && other;
  assign gv        = (state_q == ARB) ? found : (req_i[own_q] && !force_rel);
  assign gi        = (state_q == ARB) ? win : own_q;
  assign last_i    = ti_q[(RD_LAT-1)*PW +: PW];

  assign gnt_o        = (gv && reset_ni) ? (ONE << gi) : '0;
  assign mem_ena_o    = gv && reset_ni;
  assign mem_wr_ena_o = mem_ena_o && we_i[gi];
  assign mem_addr_o   = mem_ena_o ? addr_i[int'(gi)*ADDR_W +: ADDR_W] : '0;
  assign mem_wdata_o  = mem_ena_o ? wdata_i[int'(gi)*DATA_W +: DATA_W] : '0;
  assign rvalid_o     = (tv_q[RD_LAT-1] && reset_ni) ? (ONE << last_i) : '0;
  assign rdata_o      = (|rvalid_o) ? mem_rdata_i : '0;

  // lock FSM, priority pointer and relock block; blk holds a forcibly released owner until its lock_i drops
  always_comb begin
    state_d = state_q;
    rr_d    = gv ? gi : rr_q;
    own_d   = own_q;
    cnt_d   = cnt_q;
    blk_d   = blk_q & lock_i;
    if (state_q == ARB) begin
      if (found && lock_i[win] && !blk_q[win]) begin
        state_d = LOCKED;
        own_d   = win;
        cnt_d   = CW'(1);
      end
    end else if (force_rel || !lock_i[own_q]) begin
      state_d = ARB;
      cnt_d   = '0;
      if (force_rel) blk_d[own_q] = 1'b1;
    end else if (other && cnt_q != CMAX) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // read-tag pipeline: one tag per granted read, returned RD_LAT cycles later
  always_comb begin
    tv_d = '0;
    ti_d = '0;
    tv_d[0]     = gv && !we_i[gi];
    ti_d[0 +: PW] = gi;
    for (int i = 1; i < RD_LAT; i++) begin
      tv_d[i]           = tv_q[i-1];
      ti_d[i*PW +: PW]  = ti_q[(i-1)*PW +: PW];
    end
  end

`ifdef NN_ARB_STATS_EN
  // per-requester saturating stall counters
  always_comb begin
    st_d = st_q;
    for (int k = 0; k < NUM_REQ; k++)
      st_d[k*16 +: 16] = (req_i[k] && !gnt_o[k] && st_q[k*16 +: 16] != 16'hFFFF) ? st_q[k*16 +: 16] + 16'd1 : st_q[k*16 +: 16];
  end
  assign stall_cnt_o = st_q;
`endif

  // all state registers, cleared asynchronously
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= ARB;
      rr_q    <= LAST;
      own_q   <= '0;
      cnt_q   <= '0;
      blk_q   <= '0;
      tv_q    <= '0;
      ti_q    <= '0;
`ifdef NN_ARB_STATS_EN
      st_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      own_q   <= own_d;
      cnt_q   <= cnt_d;
      blk_q   <= blk_d;
      tv_q    <= tv_d;
      ti_q    <= ti_d;
`ifdef NN_ARB_STATS_EN
      st_q    <= st_d;
`endif
    end
  end
endmodule

// File: tb/tb_nn_mem_arbiter.sv
// tb_nn_mem_arbiter: directed checks of grants, lock/timeout, read return and reset for nn_mem_arbiter
module tb_nn_mem_arbiter;
  logic         clk_i = 1'b0;
  logic         reset_ni;
  logic [2:0]   req_i, we_i, lock_i, gnt_o, rvalid_o;
  logic [47:0]  addr_i;
  logic [95:0]  wdata_i;
  logic [31:0]  rdata_o, mem_wdata_o, mem_rdata_i;
  logic         mem_ena_o, mem_wr_ena_o;
  logic [15:0]  mem_addr_o;
`ifdef NN_ARB_STATS_EN
  logic [47:0]  stall_cnt_o;
`endif
  logic [31:0]  mem [0:65535];
  int           n_chk = 0;
  int           n_fail = 0;
  int           ord [6] = '{0, 1, 2, 0, 1, 2};

  nn_mem_arbiter #(.LOCK_MAX(8)) u_dut (
    .clk_i(clk_i), .reset_ni(reset_ni), .req_i(req_i), .we_i(we_i), .lock_i(lock_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
    .mem_ena_o(mem_ena_o), .mem_wr_ena_o(mem_wr_ena_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
`ifdef NN_ARB_STATS_EN
    , .stall_cnt_o(stall_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) begin
    if (mem_ena_o && mem_wr_ena_o) mem[mem_addr_o] <= mem_wdata_o;
    if (mem_ena_o) mem_rdata_i <= mem[mem_addr_o];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  initial begin
    for (int a = 0; a < 3; a++) mem[16'h10 + a] = 32'hA0 + a;
    mem[16'h5] = 32'h3F800000;
    mem_rdata_i = '0;
    reset_ni = 1'b0;
    req_i = 3'b111; we_i = '0; lock_i = '0; addr_i = '0; wdata_i = '0;
    for (int k = 0; k < 3; k++) addr_i[k*16 +: 16] = 16'h10 + 16'(k);
    #2;
    check("rst_gnt", gnt_o, 0);
    check("rst_rvalid", rvalid_o, 0);
    check("rst_rdata", rdata_o, 0);
    check("rst_mem_ena", mem_ena_o, 0);
    check("rst_mem_addr", mem_addr_o, 0);
`ifdef NN_ARB_STATS_EN
    check("rst_stall", stall_cnt_o, 0);
`endif
    @(negedge clk_i);
    reset_ni = 1'b1;
    // round robin over all three requesters
    for (int i = 0; i < 6; i++) begin
      #1;
      check("rr_gnt", gnt_o, 3'b001 << ord[i]);
      if (i > 0) begin
        check("rr_rvalid", rvalid_o, 3'b001 << ord[i-1]);
        check("rr_rdata", rdata_o, 32'hA0 + ord[i-1]);
      end
      step();
    end
    req_i = '0;
    #1;
    check("rr_rvalid_last", rvalid_o, 3'b100);
    step();
    #1;
    check("rr_idle_rvalid", rvalid_o, 0);
    check("idle_mem_ena", mem_ena_o, 0);
    // single read from requester 0
    req_i = 3'b001; addr_i[0 +: 16] = 16'h0005;
    #1;
    check("rd_gnt", gnt_o, 3'b001);
    check("rd_addr", mem_addr_o, 16'h0005);
    check("rd_wr_ena", mem_wr_ena_o, 0);
    step();
    req_i = '0;
    #1;
    check("rd_rvalid", rvalid_o, 3'b001);
    check("rd_rdata", rdata_o, 32'h3F800000);
    step();
    // requester 1 locks for four granted cycles
    req_i = 3'b111; lock_i = 3'b010;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) lock_i = 3'b000;
      #1;
      check("lk_gnt", gnt_o, 3'b010);
      step();
    end
    #1;
    check("lk_after1", gnt_o, 3'b100);
    step();
    #1;
    check("lk_after2", gnt_o, 3'b001);
    step();
    // lock timeout with requester 0 waiting
    req_i = 3'b011; lock_i = 3'b010;
    for (int i = 0; i < 8; i++) begin
      #1;
      check("to_gnt", gnt_o, 3'b010);
      step();
    end
    #1;
    check("to_release", gnt_o, 3'b000);
    step();
    #1;
    check("to_next", gnt_o, 3'b001);
    step();
    #1;
    check("to_nolock1", gnt_o, 3'b010);
    step();
    #1;
    check("to_nolock0", gnt_o, 3'b001);
    req_i = '0; lock_i = '0;
    step();
    step();
    // write from requester 2 then read back by requester 0
    req_i = 3'b100; we_i = 3'b100; addr_i[32 +: 16] = 16'h0100; wdata_i[64 +: 32] = 32'h40490FDB;
    #1;
    check("wr_gnt", gnt_o, 3'b100);
    check("wr_ena", mem_wr_ena_o, 1);
    check("wr_addr", mem_addr_o, 16'h0100);
    check("wr_data", mem_wdata_o, 32'h40490FDB);
    step();
    req_i = 3'b001; we_i = '0; addr_i[0 +: 16] = 16'h0100;
    #1;
    check("wb_gnt", gnt_o, 3'b001);
    check("wb_wr_ena", mem_wr_ena_o, 0);
    check("wr_no_rvalid", rvalid_o, 0);
    step();
    req_i = '0;
    #1;
    check("wb_rvalid", rvalid_o, 3'b001);
    check("wb_rdata", rdata_o, 32'h40490FDB);
    step();
    // reset with a read in flight
    req_i = 3'b001; addr_i[0 +: 16] = 16'h0005;
    #1;
    check("mr_gnt", gnt_o, 3'b001);
    step();
    reset_ni = 1'b0;
    #1;
    check("mr_rvalid", rvalid_o, 0);
    check("mr_rdata", rdata_o, 0);
    check("mr_gnt_rst", gnt_o, 0);
    check("mr_mem_ena", mem_ena_o, 0);
`ifdef NN_ARB_STATS_EN
    check("mr_stall", stall_cnt_o, 0);
`endif
    req_i = '0;
    step();
    reset_ni = 1'b1;
    step();
    #1;
    check("mr_post_rvalid1", rvalid_o, 0);
    step();
    #1;
    check("mr_post_rvalid2", rvalid_o, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
